mul16_seq: RTL and testbench
============================

Name: mul16_seq

Overview:
- Multi-cycle shift-and-add multiplier controller that sequences a single add16 instance.
- Provides 16x16 -> 16-bit multiply, modulo 2^16, matching Hack word arithmetic.
- Upstream and downstream use valid/ready handshakes.
- Sits beside the ALU as the multiply resource. All additions go through the internal add16; no other adder is inferred.

Parameters:
- WIDTH, 16: datapath width. Only 16 is supported, because it is fixed by add16.
- EARLY_EXIT, 1: when 1, RUN terminates once the remaining multiplier bits are all zero. When 0, RUN always takes exactly 16 cycles.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b presented
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  16  multiplicand
- b  input  16  multiplier
- out_valid  output  1  product valid (DONE only)
- out_ready  input  1  consumer accepts product
- product  output  16  low 16 bits of a*b
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; mcand, mplier, acc, count cleared to 0.
  - product=0, out_valid=0, busy=0, in_ready=1.
  - in_ready, out_valid and busy are registered.
- Reset mid-operation: operation aborted, no product delivered, same values as above.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid&&in_ready: mcand<=a, mplier<=b, acc<=0, count<=0, state<=RUN, in_ready<=0, busy<=1.
  - a and b are sampled only on that edge; later changes are ignored.
- RUN, each cycle:
  - add16 computes sum = acc + mcand, carry-out discarded.
  - If mplier[0]=1, acc<=sum; otherwise acc unchanged.
  - mcand<=mcand<<1 (bit 15 lost).
  - mplier<=mplier>>1 (zero fill).
  - count<=count+1.
  - Exit condition: count==15, or (EARLY_EXIT && (mplier>>1)==0).
  - On exit: product<=final acc, out_valid<=1, state<=DONE.
- Latency:
  - N = number of RUN cycles.
  - EARLY_EXIT=1: N = (index of highest set bit of b)+1; b=0 gives N=1.
  - EARLY_EXIT=0: N=16.
  - out_valid rises N+1 clock edges after the accepting edge.
- DONE:
  - out_valid=1; product held stable until the handshake.
  - On an edge with out_ready=1: out_valid<=0, busy<=0, in_ready<=1, state<=IDLE.
  - out_ready held low: the block stalls indefinitely with product stable.
- Simultaneous events:
  - out_ready and in_valid on the same edge: the handshake completes, but the new operands are NOT accepted, because in_ready was 0. Earliest new accept is the following edge.
  - in_valid during RUN or DONE: ignored, no queuing.
  - out_ready outside DONE: ignored.
- Arithmetic:
  - All modulo 2^16; signed and unsigned operands give identical low-16 results.
  - No overflow flag.
- Throughput: at most one multiply per N+2 cycles.

Test Plan:
- a=3, b=5, out_ready=1 -> out_valid rises 4 edges after accept (N=3); product=0x000F; in_ready returns 1 the edge after.
- a=0x1234, b=0 -> N=1; product=0x0000; then a=0, b=0xFFFF -> N=16, product=0x0000.
- a=0xFFFF, b=0xFFFF -> N=16; product=0x0001 (wrap). Also a=0x0100, b=0x0100 -> product=0x0000.
- a=0x1235, b=0x8000, out_ready held low 5 cycles after out_valid -> product=0x8000, stable throughout; in_valid pulses during RUN and DONE are ignored; accept only after the return to IDLE.
- Reset pulse (reset_n low 1 cycle) during RUN of a=7, b=9 -> immediately in_ready=1, out_valid=0, busy=0, product=0; next op a=7, b=9 -> product=0x003F.
- EARLY_EXIT=0 build, a=2, b=1 -> N=16; product=0x0002 exactly 17 edges after accept.

Source files
------------

// File: rtl/mul16_seq_if.sv
// mul16_seq_if: operand/product valid-ready handshake bundle for mul16_seq.
interface mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/mul16_seq.sv
// mul16_seq: sequential shift-and-add 16x16 -> 16-bit multiplier built around one add16.
module add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] s
);
  assign s = x + y;
endmodule

module mul16_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  mul16_seq_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] sum;
  logic [3:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             last;

  add16 u_add (.x(acc_q), .y(mcand_q), .s(sum));

  // Stop after the 16th bit, or as soon as no multiplier bits remain to add.
  assign last = (count_q == 4'd15) || (EARLY_EXIT && (mplier_q[WIDTH-1:1] == '0));

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        mcand_d    = bus.a;
        mplier_d   = bus.b;
        acc_d      = '0;
        count_d    = '0;
        state_d    = RUN;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
      RUN: begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 4'd1;
        if (last) begin
          product_d   = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: scoreboard bench for mul16_seq; latency counts edges including the accepting edge.
module tb_mul16_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mul16_seq_if bus ();
  mul16_seq_if bus0 ();

  mul16_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  mul16_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));

  typedef struct {
    logic [15:0] p;
    int          lat;
  } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] f;
    f = {16'd0, x} * {16'd0, y};
    return f[15:0];
  endfunction

  function automatic int ref_lat(input logic [15:0] y, input bit ee);
    if (!ee) return 17;
    for (int i = 15; i >= 0; i--) if (y[i]) return i + 2;
    return 2;
  endfunction

  task automatic push(input logic [15:0] x, input logic [15:0] y, input bit ee);
    exp_t e;
    e.p = ref_mul(x, y);
    e.lat = ref_lat(y, ee);
    exp_q.push_back(e);
  endtask

  task automatic send(input bit sel, input logic [15:0] x, input logic [15:0] y, output bit ok);
    int w = 0;
    while (!(sel ? bus0.in_ready : bus.in_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = (w < 50);
    if (sel) begin bus0.a = x; bus0.b = y; bus0.in_valid = 1'b1; end
    else begin bus.a = x; bus.b = y; bus.in_valid = 1'b1; end
    @(posedge clk);
    #1;
    if (sel) begin bus0.in_valid = 1'b0; bus0.a = 16'($urandom); bus0.b = 16'($urandom); end
    else begin bus.in_valid = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); end
  endtask

  task automatic wait_out(input bit sel, output int edges, output logic [15:0] p);
    edges = 1;
    @(negedge clk);
    while (!(sel ? bus0.out_valid : bus.out_valid) && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    p = sel ? bus0.product : bus.product;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.product !== 16'h0000) begin n_bad++; $display("FAIL reset_product got %h want 0000", bus.product); end
    n_cmp++; if (bus0.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_ee0 got %b want 1", bus0.in_ready); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_corners;
    logic [15:0] ta [6] = '{16'h0003, 16'h1234, 16'h0000, 16'hFFFF, 16'h0100, 16'h8001};
    logic [15:0] tb [6] = '{16'h0005, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0003};
    exp_t e;
    bit ok;
    int edges;
    logic [15:0] p;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(ta[i], tb[i], 1'b1);
      send(1'b0, ta[i], tb[i], ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL corner_accept[%0d] got in_ready=0 want 1", i); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL corner_busy[%0d] got %b want 1", i, bus.busy); end
      wait_out(1'b0, edges, p);
      e = exp_q.pop_front();
      n_cmp++; if (p !== e.p) begin n_bad++; $display("FAIL corner_product[%0d] got %h want %h", i, p, e.p); end
      n_cmp++; if (edges !== e.lat) begin n_bad++; $display("FAIL corner_latency[%0d] got %0d want %0d", i, edges, e.lat); end
      @(negedge clk);
      n_cmp++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin n_bad++; $display("FAIL corner_return[%0d] got %b want 100", i, {bus.in_ready, bus.out_valid, bus.busy}); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit ok;
    int edges;
    logic [15:0] p, x, y;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x = 16'($urandom);
      y = 16'($urandom) >> $urandom_range(0, 15);
      push(x, y, 1'b1);
      send(1'b0, x, y, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_accept[%0d] got in_ready=0 want 1", i); end
      wait_out(1'b0, edges, p);
      e = exp_q.pop_front();
      n_cmp++; if (p !== e.p) begin n_bad++; $display("FAIL b2b_product[%0d] a=%h b=%h got %h want %h", i, x, y, p, e.p); end
      n_cmp++; if (edges !== e.lat) begin n_bad++; $display("FAIL b2b_latency[%0d] b=%h got %0d want %0d", i, y, edges, e.lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    exp_t e;
    bit ok;
    int edges;
    logic [15:0] p;
    bus.out_ready = 1'b0;
    push(16'h1235, 16'h8000, 1'b1);
    send(1'b0, 16'h1235, 16'h8000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_accept got in_ready=0 want 1"); end
    bus.in_valid = 1'b1; bus.a = 16'h5555; bus.b = 16'h0001;
    wait_out(1'b0, edges, p);
    e = exp_q.pop_front();
    n_cmp++; if (p !== e.p) begin n_bad++; $display("FAIL stall_product got %h want %h", p, e.p); end
    n_cmp++; if (edges !== e.lat) begin n_bad++; $display("FAIL stall_latency got %0d want %0d", edges, e.lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({bus.out_valid, bus.in_ready, bus.busy, bus.product} !== {3'b101, e.p}) begin n_bad++; $display("FAIL stall_hold[%0d] got %b/%h want 101/%h", i, {bus.out_valid, bus.in_ready, bus.busy}, bus.product, e.p); end
    end
    bus.a = 16'h0001; bus.b = 16'h0003;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin n_bad++; $display("FAIL stall_no_same_edge_accept got %b want 100", {bus.in_ready, bus.out_valid, bus.busy}); end
    push(16'h0001, 16'h0003, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out(1'b0, edges, p);
    e = exp_q.pop_front();
    n_cmp++; if (p !== e.p) begin n_bad++; $display("FAIL stall_next_product got %h want %h", p, e.p); end
    n_cmp++; if (edges !== e.lat) begin n_bad++; $display("FAIL stall_next_latency got %0d want %0d", edges, e.lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit ok;
    int edges;
    logic seen;
    logic [15:0] p;
    bus.out_ready = 1'b1;
    push(16'h0007, 16'h0009, 1'b1);
    send(1'b0, 16'h0007, 16'h0009, ok);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.in_ready, bus.out_valid, bus.busy, bus.product} !== {3'b100, 16'h0000}) begin n_bad++; $display("FAIL midreset_state got %b/%h want 100/0000", {bus.in_ready, bus.out_valid, bus.busy}, bus.product); end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_product got out_valid=%b want 0", seen); end
    push(16'h0007, 16'h0009, 1'b1);
    send(1'b0, 16'h0007, 16'h0009, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midreset_accept got in_ready=0 want 1"); end
    wait_out(1'b0, edges, p);
    e = exp_q.pop_front();
    n_cmp++; if (p !== e.p) begin n_bad++; $display("FAIL midreset_product got %h want %h", p, e.p); end
    n_cmp++; if (edges !== e.lat) begin n_bad++; $display("FAIL midreset_latency got %0d want %0d", edges, e.lat); end
    @(negedge clk);
  endtask

  task automatic test_no_early_exit;
    logic [15:0] ta [2] = '{16'h0002, 16'hFFFF};
    logic [15:0] tb [2] = '{16'h0001, 16'hFFFF};
    exp_t e;
    bit ok;
    int edges;
    logic [15:0] p;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(ta[i], tb[i], 1'b0);
      send(1'b1, ta[i], tb[i], ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ee0_accept[%0d] got in_ready=0 want 1", i); end
      wait_out(1'b1, edges, p);
      e = exp_q.pop_front();
      n_cmp++; if (p !== e.p) begin n_bad++; $display("FAIL ee0_product[%0d] got %h want %h", i, p, e.p); end
      n_cmp++; if (edges !== e.lat) begin n_bad++; $display("FAIL ee0_latency[%0d] got %0d want %0d", i, edges, e.lat); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_corners;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_no_early_exit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
